l2_dst_mc: RTL and testbench



---
 rtl/l2_dst_mc_pkg.sv | 35 +++
 rtl/l2_dst_rr_arb.sv | 34 +++
 rtl/l2_dst_mc.sv | 207 ++++++++++++++++++++
 tb/tb_l2_dst_mc.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_dst_mc_pkg.sv
// l2_dst_mc_pkg: state encoding, ACE snoop codes and snoop response
// field positions shared by the multi-slot L2 destination stage.
package l2_dst_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP_AC,
    ST_SNOOP_CR,
    ST_SNOOP_CD,
    ST_CACHE_WB,
    ST_CACHE_REQ
  } l2_state_e;

  localparam logic [3:0] SNP_READ_SHARED = 4'h1;
  localparam logic [3:0] SNP_READ_UNIQUE = 4'h7;
  localparam logic [3:0] SNP_CLEAN_INV   = 4'h9;

  localparam int CR_BITS  = 5;
  localparam int CR_DATA  = 0;
  localparam int CR_DIRTY = 2;

  localparam int TY_WRITE  = 0;
  localparam int TY_CACHED = 1;
  localparam int TY_UNIQUE = 2;

  function automatic logic [3:0] snoop_code(input logic [2:0] typ);
    if (typ[TY_WRITE])
      return SNP_CLEAN_INV;
    else if (typ[TY_UNIQUE])
      return SNP_READ_UNIQUE;
    else
      return SNP_READ_SHARED;
  endfunction

endpackage

// File: rtl/l2_dst_rr_arb.sv
// l2_dst_rr_arb: combinational round-robin arbiter, first requester
// at or above rr_ptr wins, with wrap-around.
module l2_dst_rr_arb
  import l2_dst_mc_pkg::*;
#(
  parameter int NSLOT = 5,
  localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic [NSLOT-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [NSLOT-1:0] grant,
  output logic [PW-1:0]    idx,
  output logic             any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < NSLOT; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NSLOT) j = j - NSLOT;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/l2_dst_mc.sv
// l2_dst_mc: arbitrates NSLOT source slots, snoops the other coherent
// slots, writes back dirty snoop data, then forwards the request to L2.
module l2_dst_mc
  import l2_dst_mc_pkg::*;
#(
  parameter int               NSLOT      = 5,
  parameter int               ABITS      = 48,
  parameter int               LINE_BITS  = 256,
  parameter logic [NSLOT-1:0] SNOOP_MASK = 5'b01111,
  parameter bit               SNOOP_EN   = 1'b1,
  localparam int              SW         = $clog2(NSLOT + 1),
  localparam int              SB         = LINE_BITS / 8
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic [NSLOT-1:0]           i_req_valid,
  output logic [NSLOT-1:0]           o_req_ready,
  input  logic [NSLOT*3-1:0]         i_req_type,
  input  logic [NSLOT*ABITS-1:0]     i_req_addr,
  input  logic [NSLOT*3-1:0]         i_req_size,
  input  logic [NSLOT*LINE_BITS-1:0] i_req_wdata,
  input  logic [NSLOT*SB-1:0]        i_req_wstrb,
  output logic [NSLOT-1:0]           o_ac_valid,
  output logic [ABITS-1:0]           o_ac_addr,
  output logic [3:0]                 o_ac_snoop,
  input  logic [NSLOT-1:0]           i_ac_ready,
  input  logic [NSLOT-1:0]           i_cr_valid,
  input  logic [NSLOT*CR_BITS-1:0]   i_cr_resp,
  output logic [NSLOT-1:0]           o_cr_ready,
  input  logic [NSLOT-1:0]           i_cd_valid,
  input  logic [NSLOT*LINE_BITS-1:0] i_cd_data,
  output logic [NSLOT-1:0]           o_cd_ready,
  output logic                       o_cache_valid,
  output logic                       o_cache_write,
  output logic [ABITS-1:0]           o_cache_addr,
  output logic [2:0]                 o_cache_size,
  output logic [LINE_BITS-1:0]       o_cache_wdata,
  output logic [SB-1:0]              o_cache_wstrb,
  output logic [SW-1:0]              o_cache_srcid,
  input  logic                       i_cache_ready
);

  localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef struct packed {
    l2_state_e            state;
    logic [PW-1:0]        rr_ptr;
    logic [2:0]           typ;
    logic [3:0]           snoop;
    logic [ABITS-1:0]     addr;
    logic [2:0]           size;
    logic [LINE_BITS-1:0] wdata;
    logic [SB-1:0]        wstrb;
    logic [SW-1:0]        srcid;
    logic [NSLOT-1:0]     tgt;
    logic [NSLOT-1:0]     ac_valid;
    logic [NSLOT-1:0]     cr_ready;
    logic [NSLOT-1:0]     cd_mask;
    logic                 dirty;
    logic [PW-1:0]        dsrc;
    logic [LINE_BITS-1:0] wb_data;
  } l2_dst_mc_registers;

  localparam l2_dst_mc_registers REG_RST = '{
    state:   ST_IDLE,
    srcid:   SW'(NSLOT),
    default: '0
  };

  l2_dst_mc_registers r;

  logic [NSLOT-1:0] gnt;
  logic [PW-1:0]    gidx;
  logic             gany;

  l2_dst_rr_arb #(.NSLOT(NSLOT)) u_arb (
    .req    (i_req_valid),
    .rr_ptr (r.rr_ptr),
    .grant  (gnt),
    .idx    (gidx),
    .any    (gany)
  );

  logic [2:0]       g_typ;
  logic [NSLOT-1:0] g_tgt;
  logic             g_snp;
  logic [NSLOT-1:0] ac_left;
  logic [NSLOT-1:0] cr_hs;
  logic [NSLOT-1:0] cr_data;
  logic [NSLOT-1:0] cr_left;
  logic [NSLOT-1:0] cd_hs;
  logic [NSLOT-1:0] cd_left;
  logic             nd;
  logic [PW-1:0]    nds;
  logic [PW-1:0]    nxt_ptr;

  assign g_typ = i_req_type[gidx*3 +: 3];
  assign g_tgt = SNOOP_MASK & ~gnt;
  assign g_snp = SNOOP_EN && (g_tgt != '0)
              && (g_typ[TY_WRITE] || g_typ[TY_CACHED]);

  assign ac_left = r.ac_valid & ~i_ac_ready;
  assign cr_hs   = r.cr_ready & i_cr_valid;
  assign cr_left = r.cr_ready & ~cr_hs;
  assign cd_hs   = o_cd_ready & i_cd_valid;
  assign cd_left = r.cd_mask & ~cd_hs;

  assign nxt_ptr = (r.srcid >= SW'(NSLOT - 1)) ? '0
                 : PW'(r.srcid + 1'b1);

  // Lowest dirty responder wins, across and within cycles.
  always_comb begin
    cr_data = '0;
    nd      = r.dirty;
    nds     = r.dsrc;
    for (int i = 0; i < NSLOT; i++) begin
      if (cr_hs[i] && i_cr_resp[i*CR_BITS+CR_DATA]) begin
        cr_data[i] = 1'b1;
        if (i_cr_resp[i*CR_BITS+CR_DIRTY]
            && (!nd || PW'(i) < nds)) begin
          nd  = 1'b1;
          nds = PW'(i);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r <= REG_RST;
    end else begin
      unique case (r.state)
        ST_IDLE: begin
          if (gany) begin
            r.typ   <= g_typ;
            r.snoop <= snoop_code(g_typ);
            r.addr  <= i_req_addr[gidx*ABITS +: ABITS];
            r.size  <= i_req_size[gidx*3 +: 3];
            r.wdata <= i_req_wdata[gidx*LINE_BITS +: LINE_BITS];
            r.wstrb <= i_req_wstrb[gidx*SB +: SB];
            r.srcid <= SW'(gidx);
            r.tgt   <= g_tgt;
            if (g_snp) begin
              r.ac_valid <= g_tgt;
              r.state    <= ST_SNOOP_AC;
            end else begin
              r.state <= ST_CACHE_REQ;
            end
          end
        end
        ST_SNOOP_AC: begin
          r.ac_valid <= ac_left;
          if (ac_left == '0) begin
            r.cr_ready <= r.tgt;
            r.state    <= ST_SNOOP_CR;
          end
        end
        ST_SNOOP_CR: begin
          r.cr_ready <= cr_left;
          r.cd_mask  <= r.cd_mask | cr_data;
          r.dirty    <= nd;
          r.dsrc     <= nds;
          if (cr_left == '0)
            r.state <= ((r.cd_mask | cr_data) != '0)
                     ? ST_SNOOP_CD : ST_CACHE_REQ;
        end
        ST_SNOOP_CD: begin
          r.cd_mask <= cd_left;
          if (r.dirty && cd_hs[r.dsrc])
            r.wb_data <= i_cd_data[r.dsrc*LINE_BITS +: LINE_BITS];
          if (cd_left == '0)
            r.state <= r.dirty ? ST_CACHE_WB : ST_CACHE_REQ;
        end
        ST_CACHE_WB: begin
          if (i_cache_ready) r.state <= ST_CACHE_REQ;
        end
        ST_CACHE_REQ: begin
          if (i_cache_ready) begin
            r.state   <= ST_IDLE;
            r.rr_ptr  <= nxt_ptr;
            r.dirty   <= 1'b0;
            r.cd_mask <= '0;
          end
        end
        default: r <= REG_RST;
      endcase
    end
  end

  logic wb;
  assign wb = (r.state == ST_CACHE_WB);

  assign o_req_ready   = (r.state == ST_IDLE) ? gnt : '0;
  assign o_ac_valid    = r.ac_valid;
  assign o_ac_addr     = r.addr;
  assign o_ac_snoop    = r.snoop;
  assign o_cr_ready    = r.cr_ready;
  assign o_cd_ready    = (r.state == ST_SNOOP_CD) ? r.cd_mask : '0;
  assign o_cache_valid = wb || (r.state == ST_CACHE_REQ);
  assign o_cache_write = wb || r.typ[TY_WRITE];
  assign o_cache_addr  = r.addr;
  assign o_cache_size  = r.size;
  assign o_cache_wdata = wb ? r.wb_data : r.wdata;
  assign o_cache_wstrb = wb ? '1 : r.wstrb;
  assign o_cache_srcid = wb ? SW'(NSLOT) : r.srcid;

endmodule

// File: tb/tb_l2_dst_mc.sv
// tb_l2_dst_mc: directed table vectors plus hand-written sequences for
// arbitration, dirty write-back, staggered snoops, stall and reset.
module tb_l2_dst_mc;

  localparam int N  = 5;
  localparam int AB = 48;
  localparam int LB = 256;
  localparam int SB = LB / 8;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*3-1:0]  req_type;
  logic [N*AB-1:0] req_addr;
  logic [N*3-1:0]  req_size;
  logic [N*LB-1:0] req_wdata;
  logic [N*SB-1:0] req_wstrb;
  logic [N-1:0]    ac_valid;
  logic [AB-1:0]   ac_addr;
  logic [3:0]      ac_snoop;
  logic [N-1:0]    ac_ready;
  logic [N-1:0]    cr_valid;
  logic [N*5-1:0]  cr_resp;
  logic [N-1:0]    cr_ready;
  logic [N-1:0]    cd_valid;
  logic [N*LB-1:0] cd_data;
  logic [N-1:0]    cd_ready;
  logic            cache_valid;
  logic            cache_write;
  logic [AB-1:0]   cache_addr;
  logic [2:0]      cache_size;
  logic [LB-1:0]   cache_wdata;
  logic [SB-1:0]   cache_wstrb;
  logic [SW-1:0]   cache_srcid;
  logic            cache_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_dst_mc dut (
    .i_clk         (clk),
    .i_nrst        (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_type    (req_type),
    .i_req_addr    (req_addr),
    .i_req_size    (req_size),
    .i_req_wdata   (req_wdata),
    .i_req_wstrb   (req_wstrb),
    .o_ac_valid    (ac_valid),
    .o_ac_addr     (ac_addr),
    .o_ac_snoop    (ac_snoop),
    .i_ac_ready    (ac_ready),
    .i_cr_valid    (cr_valid),
    .i_cr_resp     (cr_resp),
    .o_cr_ready    (cr_ready),
    .i_cd_valid    (cd_valid),
    .i_cd_data     (cd_data),
    .o_cd_ready    (cd_ready),
    .o_cache_valid (cache_valid),
    .o_cache_write (cache_write),
    .o_cache_addr  (cache_addr),
    .o_cache_size  (cache_size),
    .o_cache_wdata (cache_wdata),
    .o_cache_wstrb (cache_wstrb),
    .o_cache_srcid (cache_srcid),
    .i_cache_ready (cache_ready)
  );

  typedef struct {
    int           slot;
    logic [2:0]   typ;
    logic [AB-1:0] addr;
    logic [N-1:0] ac;
    logic [3:0]   code;
  } vec_t;

  vec_t vt[7];

  function automatic logic [LB-1:0] wd(input int s);
    logic [7:0] b;
    b = 8'h30 + 8'(s);
    return {SB{b}};
  endfunction

  function automatic logic [SB-1:0] ws(input int s);
    return 32'hF0F0_0000 | 32'(s);
  endfunction

  task automatic chk(input string nm, input logic [LB-1:0] act,
                     input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int s, input logic [2:0] t,
                      input logic [AB-1:0] a);
    req_type[s*3 +: 3]   = t;
    req_addr[s*AB +: AB] = a;
    req_size[s*3 +: 3]   = 3'd5;
    req_wdata[s*LB +: LB] = wd(s);
    req_wstrb[s*SB +: SB] = ws(s);
  endtask

  task automatic do_cache(input string nm, input logic w,
                          input logic [AB-1:0] a, input logic [SW-1:0] sid,
                          input logic [LB-1:0] d, input logic [SB-1:0] s);
    #1;
    chk({nm, "_valid"}, cache_valid, 1'b1);
    chk({nm, "_write"}, cache_write, w);
    chk({nm, "_addr"}, cache_addr, a);
    chk({nm, "_srcid"}, cache_srcid, sid);
    chk({nm, "_wdata"}, cache_wdata, d);
    chk({nm, "_wstrb"}, cache_wstrb, s);
    cache_ready = 1'b1;
    tick();
    cache_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_type = '0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wstrb = '0;
    ac_ready = '0; cr_valid = '0; cr_resp = '0;
    cd_valid = '0; cd_data = '0; cache_ready = 1'b0;

    vt[0] = '{4, 3'b001, 48'h1000, 5'b01111, 4'h9};
    vt[1] = '{0, 3'b010, 48'h1040, 5'b01110, 4'h1};
    vt[2] = '{1, 3'b110, 48'h1080, 5'b01101, 4'h7};
    vt[3] = '{2, 3'b000, 48'h10c0, 5'b00000, 4'h1};
    vt[4] = '{3, 3'b011, 48'h1100, 5'b00111, 4'h9};
    vt[5] = '{1, 3'b100, 48'h1140, 5'b00000, 4'h7};
    vt[6] = '{4, 3'b110, 48'h1180, 5'b01111, 4'h7};

    #12;
    chk("rst_cache_valid", cache_valid, 1'b0);
    chk("rst_srcid", cache_srcid, 3'd5);
    chk("rst_ac_valid", ac_valid, '0);
    chk("rst_wdata", cache_wdata, '0);
    rst_n = 1'b1;
    tick();

    // Round-robin: slots 1 and 3 together from rr_ptr=0
    load(1, 3'b000, 48'h100);
    load(3, 3'b000, 48'h300);
    req_valid = 5'b01010;
    #1 chk("arb_first", req_ready, 5'b00010);
    tick();
    req_valid = 5'b01000;
    #1 chk("arb_busy_ready", req_ready, '0);
    do_cache("arb_s1", 1'b0, 48'h100, 3'd1, wd(1), ws(1));
    #1 chk("arb_second", req_ready, 5'b01000);
    chk("arb_idle_valid", cache_valid, 1'b0);
    tick();
    req_valid = '0;
    do_cache("arb_s3", 1'b0, 48'h300, 3'd3, wd(3), ws(3));
    load(0, 3'b000, 48'h0);
    load(4, 3'b000, 48'h400);
    req_valid = 5'b10001;
    #1 chk("arb_ptr4", req_ready, 5'b10000);
    tick();
    req_valid = '0;
    do_cache("arb_s4", 1'b0, 48'h400, 3'd4, wd(4), ws(4));

    // Table-driven single-slot transactions, clean snoop responses
    for (int k = 0; k < 7; k++) begin
      load(vt[k].slot, vt[k].typ, vt[k].addr);
      req_valid = '0;
      req_valid[vt[k].slot] = 1'b1;
      #1;
      chk($sformatf("v%0d_grant", k), req_ready, req_valid);
      tick();
      req_valid = '0;
      #1;
      chk($sformatf("v%0d_ac", k), ac_valid, vt[k].ac);
      if (vt[k].ac != '0) begin
        chk($sformatf("v%0d_code", k), ac_snoop, vt[k].code);
        chk($sformatf("v%0d_acaddr", k), ac_addr, vt[k].addr);
        ac_ready = '1;
        tick();
        ac_ready = '0;
        #1 chk($sformatf("v%0d_cr", k), cr_ready, vt[k].ac);
        cr_valid = '1;
        cr_resp = '0;
        tick();
        cr_valid = '0;
        #1 chk($sformatf("v%0d_cd", k), cd_ready, '0);
      end
      chk($sformatf("v%0d_size", k), cache_size, 3'd5);
      do_cache($sformatf("v%0d", k), vt[k].typ[0], vt[k].addr,
               SW'(vt[k].slot), wd(vt[k].slot), ws(vt[k].slot));
    end

    // Dirty snoop data from slot 2, clean data from slot 1 drained
    load(0, 3'b110, 48'h2000);
    req_valid = 5'b00001;
    tick();
    req_valid = '0;
    #1 chk("dty_ac", ac_valid, 5'b01110);
    chk("dty_code", ac_snoop, 4'h7);
    ac_ready = '1;
    tick();
    ac_ready = '0;
    #1 chk("dty_cr", cr_ready, 5'b01110);
    cr_valid = 5'b01110;
    cr_resp = '0;
    cr_resp[1*5 +: 5] = 5'b00001;
    cr_resp[2*5 +: 5] = 5'b00101;
    tick();
    cr_valid = '0;
    cr_resp = '0;
    #1 chk("dty_cd", cd_ready, 5'b00110);
    chk("dty_cd_noval", cache_valid, 1'b0);
    cd_valid = 5'b00110;
    cd_data[1*LB +: LB] = {SB{8'h5A}};
    cd_data[2*LB +: LB] = {SB{8'hA5}};
    tick();
    cd_valid = '0;
    do_cache("dty_wb", 1'b1, 48'h2000, 3'd5, {SB{8'hA5}}, '1);
    do_cache("dty_req", 1'b0, 48'h2000, 3'd0, wd(0), ws(0));

    // Staggered AC: slot 1 accepts three cycles late
    load(2, 3'b010, 48'h3000);
    req_valid = 5'b00100;
    tick();
    req_valid = '0;
    #1 chk("stg_ac0", ac_valid, 5'b01011);
    ac_ready = 5'b01001;
    tick();
    ac_ready = '0;
    #1 chk("stg_ac1", ac_valid, 5'b00010);
    chk("stg_cr1", cr_ready, '0);
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("stg_hold_ac%0d", c), ac_valid, 5'b00010);
      chk($sformatf("stg_hold_cr%0d", c), cr_ready, '0);
    end
    ac_ready = 5'b00010;
    tick();
    ac_ready = '0;
    #1 chk("stg_ac_done", ac_valid, '0);
    chk("stg_cr_open", cr_ready, 5'b01011);
    cr_valid = 5'b00001;
    tick();
    #1 chk("stg_cr_part", cr_ready, 5'b01010);
    cr_valid = 5'b01011;
    cr_resp[0 +: 5] = 5'b00101;
    tick();
    cr_valid = '0;
    cr_resp = '0;
    #1 chk("stg_no_cd", cd_ready, '0);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall_valid%0d", c), cache_valid, 1'b1);
      chk($sformatf("stall_addr%0d", c), cache_addr, 48'h3000);
      chk($sformatf("stall_src%0d", c), cache_srcid, 3'd2);
      chk($sformatf("stall_wr%0d", c), cache_write, 1'b0);
      tick();
    end
    do_cache("stall_done", 1'b0, 48'h3000, 3'd2, wd(2), ws(2));
    #1 chk("stall_idle", cache_valid, 1'b0);

    // Reset in SnoopCd
    load(3, 3'b001, 48'h4000);
    req_valid = 5'b01000;
    tick();
    req_valid = '0;
    #1 chk("rsd_ac", ac_valid, 5'b00111);
    ac_ready = '1;
    tick();
    ac_ready = '0;
    cr_valid = 5'b00111;
    cr_resp[0 +: 5] = 5'b00101;
    tick();
    cr_valid = '0;
    cr_resp = '0;
    #1 chk("rsd_cd", cd_ready, 5'b00001);
    rst_n = 1'b0;
    #1;
    chk("rsd_cd0", cd_ready, '0);
    chk("rsd_ac0", ac_valid, '0);
    chk("rsd_cr0", cr_ready, '0);
    chk("rsd_valid0", cache_valid, 1'b0);
    chk("rsd_srcid", cache_srcid, 3'd5);
    chk("rsd_addr0", cache_addr, '0);
    chk("rsd_snoop0", ac_snoop, '0);
    tick();
    rst_n = 1'b1;
    load(0, 3'b000, 48'h5000);
    load(4, 3'b000, 48'h5400);
    req_valid = 5'b10001;
    #1 chk("rsd_ptr0", req_ready, 5'b00001);
    tick();
    req_valid = '0;
    do_cache("rsd_req", 1'b0, 48'h5000, 3'd0, wd(0), ws(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
